rrv_issue_stage: RTL and testbench

Decode/operand stage of the RRV RV32I core, directly upstream of the ALU. It decodes a 32-bit instruction word into the 4-bit ALU function code ({IR[30], IR[14:12]} encoding). It selects and forwards the two operands and registers the result into a single pipeline slot with a valid/ready handshake, and the ALU consumes the slot's outputs combinationally. The register file is external and is read combinationally through the address outputs.

---
 rtl/rrv_issue_stage_pkg.sv | 39 +++
 rtl/rrv_decoder.sv | 81 ++++++++
 rtl/rrv_issue_stage.sv | 101 ++++++++++
 tb/tb_rrv_issue_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rrv_issue_stage_pkg.sv
// Shared constants and types for the RRV issue stage: widths, opcodes,
// ALU function codes and the decoded-instruction payload.
`timescale 1ns/1ps
package rrv_issue_stage_pkg;

  localparam int REG_WIDTH = 32;
  localparam int FUNC_SIZE = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU function codes are {instr[30], funct3}
  localparam logic [FUNC_SIZE-1:0] FUNC_ADD  = 4'b0000;
  localparam logic [FUNC_SIZE-1:0] FUNC_SUB  = 4'b1000;
  localparam logic [FUNC_SIZE-1:0] FUNC_SLL  = 4'b0001;
  localparam logic [FUNC_SIZE-1:0] FUNC_SLT  = 4'b0010;
  localparam logic [FUNC_SIZE-1:0] FUNC_SLTU = 4'b0011;
  localparam logic [FUNC_SIZE-1:0] FUNC_XOR  = 4'b0100;
  localparam logic [FUNC_SIZE-1:0] FUNC_SRL  = 4'b0101;
  localparam logic [FUNC_SIZE-1:0] FUNC_SRA  = 4'b1101;
  localparam logic [FUNC_SIZE-1:0] FUNC_OR   = 4'b0110;
  localparam logic [FUNC_SIZE-1:0] FUNC_AND  = 4'b0111;

  typedef struct packed {
    logic [FUNC_SIZE-1:0] func;
    logic [REG_WIDTH-1:0] in1;
    logic [REG_WIDTH-1:0] in2;
    logic [4:0]           rd;
    logic                 rd_we;
    logic                 illegal;
  } issue_pkt_t;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/rrv_decoder.sv
// Combinational RV32I ALU-class decoder: opcode/funct checks, immediate
// generation and operand selection into one issue payload.
`timescale 1ns/1ps
module rrv_decoder
  import rrv_issue_stage_pkg::*;
(
  input  logic [31:0]          instr_i,
  input  logic [REG_WIDTH-1:0] pc_i,
  input  logic [REG_WIDTH-1:0] op1_i,
  input  logic [REG_WIDTH-1:0] op2_i,
  output issue_pkt_t           pkt_o
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [REG_WIDTH-1:0] imm_i;
  logic [REG_WIDTH-1:0] imm_u;
  logic                 legal;
  logic                 shift_op;
  logic [FUNC_SIZE-1:0] func;
  logic [REG_WIDTH-1:0] in1;
  logic [REG_WIDTH-1:0] in2;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    legal    = 1'b0;
    shift_op = 1'b0;
    func     = FUNC_ADD;
    in1      = '0;
    in2      = '0;
    unique case (opcode)
      OPC_OP: begin
        legal    = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        func     = {instr_i[30], funct3};
        in1      = op1_i;
        in2      = op2_i;
        shift_op = is_shift(funct3);
      end
      OPC_OP_IMM: begin
        unique case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        func     = {instr_i[30] & (funct3 == 3'b101), funct3};
        in1      = op1_i;
        in2      = imm_i;
        shift_op = is_shift(funct3);
      end
      OPC_LUI: begin
        legal = 1'b1;
        in2   = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        in1   = pc_i;
        in2   = imm_u;
      end
      default: legal = 1'b0;
    endcase

    // The ALU shifts by its whole operand; clearing the upper bits gives ISA shamt semantics
    if (shift_op) in2[REG_WIDTH-1:5] = '0;

    pkt_o.rd      = instr_i[11:7];
    pkt_o.rd_we   = legal && (instr_i[11:7] != 5'd0);
    pkt_o.illegal = !legal;
    pkt_o.func    = legal ? func : FUNC_ADD;
    pkt_o.in1     = legal ? in1  : '0;
    pkt_o.in2     = legal ? in2  : '0;
  end

endmodule

// File: rtl/rrv_issue_stage.sv
// RRV decode/operand stage: register-file addressing, same-cycle writeback
// forwarding and a single valid/ready pipeline slot feeding the ALU.
`timescale 1ns/1ps
module rrv_issue_stage
  import rrv_issue_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [REG_WIDTH-1:0] pc,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [REG_WIDTH-1:0] rs1_data,
  input  logic [REG_WIDTH-1:0] rs2_data,
  input  logic                 wb_en,
  input  logic [4:0]           wb_rd,
  input  logic [REG_WIDTH-1:0] wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FUNC_SIZE-1:0] out_func,
  output logic [REG_WIDTH-1:0] out_in1,
  output logic [REG_WIDTH-1:0] out_in2,
  output logic [4:0]           out_rd,
  output logic                 out_rd_we,
  output logic                 out_illegal
);

  logic [REG_WIDTH-1:0] op1;
  logic [REG_WIDTH-1:0] op2;
  issue_pkt_t           pkt_dec;
  issue_pkt_t           pkt_d, pkt_q;
  logic                 valid_d, valid_q;
  logic                 capture;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  function automatic logic [REG_WIDTH-1:0] read_operand(
    input logic [4:0]           addr,
    input logic [REG_WIDTH-1:0] rf_data,
    input logic                 fwd_en,
    input logic [4:0]           fwd_rd,
    input logic [REG_WIDTH-1:0] fwd_data
  );
    if (addr == 5'd0)                                  return '0;
    else if (fwd_en && (fwd_rd != 5'd0) && (fwd_rd == addr)) return fwd_data;
    else                                               return rf_data;
  endfunction

  assign op1 = read_operand(rs1_addr, rs1_data, wb_en, wb_rd, wb_data);
  assign op2 = read_operand(rs2_addr, rs2_data, wb_en, wb_rd, wb_data);

  rrv_decoder u_decoder (
    .instr_i (instr),
    .pc_i    (pc),
    .op1_i   (op1),
    .op2_i   (op2),
    .pkt_o   (pkt_dec)
  );

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  // Payload only moves on capture, so a stalled or flushed slot never toggles
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pkt_d   = pkt_dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the payload is reset as well because every output must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_func    = pkt_q.func;
  assign out_in1     = pkt_q.in1;
  assign out_in2     = pkt_q.in2;
  assign out_rd      = pkt_q.rd;
  assign out_rd_we   = pkt_q.rd_we;
  assign out_illegal = pkt_q.illegal;

endmodule

// File: tb/tb_rrv_issue_stage.sv
// Directed-vector bench for rrv_issue_stage: decode cases, forwarding,
// stall/no-bubble handshake, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_rrv_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_func;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  logic [31:0] rf [32];

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always #5 clk = ~clk;

  rrv_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_func   (out_func),
    .out_in1    (out_in1),
    .out_in2    (out_in2),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .out_illegal(out_illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic we,
                           input logic ill);
    check({tag, ".valid"},   {31'd0, out_valid},   32'd1);
    check({tag, ".func"},    {28'd0, out_func},    {28'd0, f});
    check({tag, ".in1"},     out_in1,              a);
    check({tag, ".in2"},     out_in2,              b);
    if (!ill) check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
    check({tag, ".rd_we"},   {31'd0, out_rd_we},   {31'd0, we});
    check({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  // Offer one beat with the downstream ready, capture it, then drop in_valid
  task automatic beat(input logic [31:0] ins, input logic [31:0] p);
    instr     = ins;
    pc        = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SRAI  = 32'h40335293; // srai x5,x6,3
  localparam logic [31:0] I_SLL   = 32'h00209233; // sll  x4,x1,x2
  localparam logic [31:0] I_ADDIM = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_ADDI  = 32'h00508113; // addi x2,x1,5
  localparam logic [31:0] I_LUI   = 32'h123453B7; // lui  x7,0x12345
  localparam logic [31:0] I_AUIPC = 32'h00001417; // auipc x8,1
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] I_LW    = 32'h00012083; // lw   x1,0(x2)
  localparam logic [31:0] I_BADX  = 32'h4020C1B3; // xor with funct7=0100000
  localparam logic [31:0] I_BADSL = 32'h40009093; // slli with funct7=0100000
  localparam logic [31:0] I_ANDI  = 32'h4000F093; // andi x1,x1,0x400
  localparam logic [31:0] I_ADDX0 = 32'h00208033; // add  x0,x1,x2

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    pc        = '0;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[0] = 32'hBADB_AD00;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[6] = 32'h8000_0000;

    #12;
    check("reset.valid",   {31'd0, out_valid},   32'd0);
    check("reset.func",    {28'd0, out_func},    32'd0);
    check("reset.in1",     out_in1,              32'd0);
    check("reset.in2",     out_in2,              32'd0);
    check("reset.rd",      {27'd0, out_rd},      32'd0);
    check("reset.rd_we",   {31'd0, out_rd_we},   32'd0);
    check("reset.illegal", {31'd0, out_illegal}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    instr = I_ADD;
    #1;
    check("add.rs1_addr", {27'd0, rs1_addr}, 32'd1);
    check("add.rs2_addr", {27'd0, rs2_addr}, 32'd2);
    beat(I_ADD, 32'h0);
    check_out("add", 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);

    beat(I_SRAI, 32'h4);
    check_out("srai", 4'b1101, 32'h8000_0000, 32'h3, 5'd5, 1'b1, 1'b0);

    rf[2] = 32'hFFFF_FF21;
    beat(I_SLL, 32'h8);
    check_out("sll", 4'b0001, 32'd5, 32'h1, 5'd4, 1'b1, 1'b0);
    rf[2] = 32'd7;

    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd9;
    beat(I_ADDIM, 32'hC);
    check_out("addi_x0", 4'b0000, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);

    wb_rd = 5'd1; wb_data = 32'hDEAD_0001;
    beat(I_ADDI, 32'h10);
    check_out("fwd_rs1", 4'b0000, 32'hDEAD_0001, 32'd5, 5'd2, 1'b1, 1'b0);

    wb_rd = 5'd2; wb_data = 32'h0000_0100;
    beat(I_ADD, 32'h14);
    check_out("fwd_rs2", 4'b0000, 32'd5, 32'h100, 5'd3, 1'b1, 1'b0);
    wb_en = 1'b0;

    beat(I_LUI, 32'h18);
    check_out("lui", 4'b0000, 32'd0, 32'h1234_5000, 5'd7, 1'b1, 1'b0);

    beat(I_AUIPC, 32'h80);
    check_out("auipc", 4'b0000, 32'h80, 32'h1000, 5'd8, 1'b1, 1'b0);

    beat(I_SUB, 32'h84);
    check_out("sub", 4'b1000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);

    beat(I_LW, 32'h88);
    check_out("bad_opc", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    beat(I_BADX, 32'h8C);
    check_out("bad_f7_op", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    beat(I_BADSL, 32'h90);
    check_out("bad_f7_slli", 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    beat(I_ANDI, 32'h94);
    check_out("andi_b30", 4'b0111, 32'd5, 32'h400, 5'd1, 1'b1, 1'b0);

    beat(I_ADDX0, 32'h98);
    check_out("rd_x0", 4'b0000, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);

    // Consume without capture empties the slot
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain.valid", {31'd0, out_valid}, 32'd0);

    // Stall: slot holds ADD while LUI waits upstream
    beat(I_ADD, 32'hA0);
    instr = I_LUI; pc = 32'hA4; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("stall.in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_out("stall", 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      check("stall.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_out("b2b_lui", 4'b0000, 32'd0, 32'h1234_5000, 5'd7, 1'b1, 1'b0);
    instr = I_AUIPC; pc = 32'hA8;
    @(posedge clk);
    #1;
    check_out("b2b_auipc", 4'b0000, 32'hA8, 32'h1000, 5'd8, 1'b1, 1'b0);

    // Flush with a full slot and a beat that would otherwise be captured
    instr = I_ADD; pc = 32'hAC; flush = 1'b1;
    #1;
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("flush.no_late", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a stall
    beat(I_SUB, 32'hB0);
    instr = I_LUI; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("prerst.valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid",   {31'd0, out_valid},   32'd0);
    check("arst.func",    {28'd0, out_func},    32'd0);
    check("arst.in1",     out_in1,              32'd0);
    check("arst.in2",     out_in2,              32'd0);
    check("arst.rd",      {27'd0, out_rd},      32'd0);
    check("arst.rd_we",   {31'd0, out_rd_we},   32'd0);
    check("arst.illegal", {31'd0, out_illegal}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst.valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
